// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the sized data memory.
// Used by dmem_lane_align and data_memory_sized.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << addr;
            SZ_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr, 3'b000} +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extend = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Misalignment, reserved size and conflicting read+write all reject the access.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr,
                                          input logic rd, input logic wr);
        access_error = (rd && wr)
                     || (size == SZ_RSVD)
                     || (size == SZ_HALF && addr[0])
                     || (size == SZ_WORD && addr != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication/byte enables and
// load extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] ram_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    // Replicate right-justified store data across all lanes; byte enables pick the target.
    always_comb begin
        case (size_i)
            SZ_BYTE: wdata_o = {4{store_data_i[7:0]}};
            SZ_HALF: wdata_o = {2{store_data_i[15:0]}};
            default: wdata_o = store_data_i;
        endcase
    end

    assign byte_en_o   = lane_mask(size_i, addr_lo_i);
    assign load_data_o = load_extend(ram_word_i, size_i, addr_lo_i, unsigned_i);

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed word RAM with handshake, wait states and alignment checks.
// Optional DMEM_STATS_EN adds saturating ReadCount/WriteCount outputs.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  Ready,
    output logic                  Error
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]           ReadCount,
    output logic [15:0]           WriteCount
`endif
);

    localparam int unsigned DEPTH     = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 32'd0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  rd_q;
    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           read_data_q;
    logic                  ready_q;
    logic                  error_q;
    logic [31:0]           mem [DEPTH];

    logic                  idle_s;
    logic                  req_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [1:0]            acc_size_s;
    logic                  acc_uns_s;
    logic                  acc_rd_s;
    logic                  acc_wr_s;
    logic [31:0]           acc_wdata_s;
    logic                  err_s;
    logic                  enter_resp_s;
    logic                  commit_wr_s;
    logic [31:0]           ram_word_s;
    logic [3:0]            byte_en_s;
    logic [31:0]           merge_data_s;
    logic [31:0]           load_data_s;

    // With zero wait states the access commits on its accept edge, so use live inputs in IDLE.
    always_comb begin
        idle_s       = (state_q == ST_IDLE);
        req_s        = MemoryRead | MemoryWrite;
        acc_addr_s   = idle_s ? Address     : addr_q;
        acc_size_s   = idle_s ? Size        : size_q;
        acc_uns_s    = idle_s ? Unsigned    : uns_q;
        acc_rd_s     = idle_s ? MemoryRead  : rd_q;
        acc_wr_s     = idle_s ? MemoryWrite : wr_q;
        acc_wdata_s  = idle_s ? WriteData   : wdata_q;
        err_s        = access_error(acc_size_s, acc_addr_s[1:0], acc_rd_s, acc_wr_s);
        enter_resp_s = (idle_s && req_s && (WAIT_STATES == 32'd0))
                     || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
        commit_wr_s  = Reset_n && enter_resp_s && acc_wr_s && !err_s;
        ram_word_s   = mem[acc_addr_s[ADDR_WIDTH-1:2]];
    end

    dmem_lane_align u_align (
        .size_i       (acc_size_s),
        .addr_lo_i    (acc_addr_s[1:0]),
        .unsigned_i   (acc_uns_s),
        .store_data_i (acc_wdata_s),
        .ram_word_i   (ram_word_s),
        .byte_en_o    (byte_en_s),
        .wdata_o      (merge_data_s),
        .load_data_o  (load_data_s)
    );

    // RAM byte-lane merge; contents deliberately survive reset.
    always_ff @(posedge Clock) begin
        for (int b = 0; b < 4; b++) begin
            if (commit_wr_s && byte_en_s[b]) begin
                mem[acc_addr_s[ADDR_WIDTH-1:2]][8*b +: 8] <= merge_data_s[8*b +: 8];
            end
        end
    end

    // Handshake FSM, request capture and registered response outputs.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            ready_q <= enter_resp_s;
            error_q <= enter_resp_s && err_s;
            if (enter_resp_s && acc_rd_s && !err_s) begin
                read_data_q <= load_data_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        addr_q  <= Address;
                        size_q  <= Size;
                        uns_q   <= Unsigned;
                        rd_q    <= MemoryRead;
                        wr_q    <= MemoryWrite;
                        wdata_q <= WriteData;
                        if (WAIT_STATES == 32'd0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ReadData = read_data_q;
    assign Ready    = ready_q;
    assign Error    = error_q;

`ifdef DMEM_STATS_EN
    logic [15:0] read_cnt_q;
    logic [15:0] write_cnt_q;

    // Saturating counters of successful completions.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            read_cnt_q  <= 16'd0;
            write_cnt_q <= 16'd0;
        end else begin
            if (enter_resp_s && !err_s && acc_rd_s && (read_cnt_q != 16'hFFFF)) begin
                read_cnt_q <= read_cnt_q + 16'd1;
            end
            if (enter_resp_s && !err_s && acc_wr_s && (write_cnt_q != 16'hFFFF)) begin
                write_cnt_q <= write_cnt_q + 16'd1;
            end
        end
    end

    assign ReadCount  = read_cnt_q;
    assign WriteCount = write_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: one instance with one wait state, one with none.
module tb_data_memory_sized;

    logic        clk;
    logic [1:0]  rst_n;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [7:0]  addr  [2];
    logic [1:0]  size  [2];
    logic [1:0]  uns;
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  ready;
    logic [1:0]  err;
`ifdef DMEM_STATS_EN
    logic [15:0] rcnt [2];
    logic [15:0] wcnt [2];
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[23];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_sized #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut_ws1 (
        .Clock(clk), .Reset_n(rst_n[0]), .MemoryRead(rd[0]), .MemoryWrite(wr[0]),
        .Address(addr[0]), .Size(size[0]), .Unsigned(uns[0]), .WriteData(wdata[0]),
        .ReadData(rdata[0]), .Ready(ready[0]), .Error(err[0])
`ifdef DMEM_STATS_EN
        , .ReadCount(rcnt[0]), .WriteCount(wcnt[0])
`endif
    );

    data_memory_sized #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
        .Clock(clk), .Reset_n(rst_n[1]), .MemoryRead(rd[1]), .MemoryWrite(wr[1]),
        .Address(addr[1]), .Size(size[1]), .Unsigned(uns[1]), .WriteData(wdata[1]),
        .ReadData(rdata[1]), .Ready(ready[1]), .Error(err[1])
`ifdef DMEM_STATS_EN
        , .ReadCount(rcnt[1]), .WriteCount(wcnt[1])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input logic r, input logic w, input logic [7:0] a,
                                input logic [1:0] s, input logic u, input logic [31:0] d,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.sel = sel; v.rd = r; v.wr = w; v.addr = a; v.size = s; v.uns = u;
        v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic idle_inputs(input int sel);
        rd[sel] = 1'b0; wr[sel] = 1'b0; addr[sel] = 8'h00; size[sel] = 2'b00;
        uns[sel] = 1'b0; wdata[sel] = 32'h0;
    endtask

    task automatic run_access(input vec_t v);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        rd[v.sel] = v.rd; wr[v.sel] = v.wr; addr[v.sel] = v.addr; size[v.sel] = v.size;
        uns[v.sel] = v.uns; wdata[v.sel] = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = (v.sel == 0) ? 2 : 1;
        sb.push_back(e);
        @(posedge clk);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) idle_inputs(v.sel);
            if (ready[v.sel]) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            check($sformatf("timeout@%h", v.addr), 32'(n), 32'(e.lat));
        end else begin
            check($sformatf("latency@%h", v.addr), 32'(n), 32'(e.lat));
            check($sformatf("error@%h", v.addr), {31'd0, err[v.sel]}, {31'd0, e.err});
            check($sformatf("rdata@%h", v.addr), rdata[v.sel], e.rdata);
        end
    endtask

    initial begin
        int cnt;
        idle_inputs(0);
        idle_inputs(1);
        rst_n = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 2'b11;
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", {31'd0, ready[i]}, 32'd0);
            check("reset_error", {31'd0, err[i]}, 32'd0);
            check("reset_rdata", rdata[i], 32'd0);
        end

        vecs[0]  = mk(0, 1, 0, 8'h10, 2'b10, 0, 32'h0,        32'h0,        0);
        vecs[0]  = mk(0, 0, 1, 8'h10, 2'b10, 0, 32'hDEADBEEF, 32'h00000000, 0);
        vecs[1]  = mk(0, 1, 0, 8'h10, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(0, 0, 1, 8'h12, 2'b00, 0, 32'h00000055, 32'hDEADBEEF, 0);
        vecs[3]  = mk(0, 1, 0, 8'h10, 2'b10, 0, 32'h0,        32'hDE55BEEF, 0);
        vecs[4]  = mk(0, 1, 0, 8'h13, 2'b00, 0, 32'h0,        32'hFFFFFFDE, 0);
        vecs[5]  = mk(0, 1, 0, 8'h13, 2'b00, 1, 32'h0,        32'h000000DE, 0);
        vecs[6]  = mk(0, 1, 0, 8'h10, 2'b01, 0, 32'h0,        32'hFFFFBEEF, 0);
        vecs[7]  = mk(0, 1, 0, 8'h10, 2'b01, 1, 32'h0,        32'h0000BEEF, 0);
        vecs[8]  = mk(0, 1, 0, 8'h11, 2'b01, 1, 32'h0,        32'h0000BEEF, 1);
        vecs[9]  = mk(0, 0, 1, 8'h20, 2'b10, 0, 32'h01020304, 32'h0000BEEF, 0);
        vecs[10] = mk(0, 1, 1, 8'h20, 2'b10, 0, 32'hAAAAAAAA, 32'h0000BEEF, 1);
        vecs[11] = mk(0, 1, 0, 8'h20, 2'b10, 0, 32'h0,        32'h01020304, 0);
        vecs[12] = mk(0, 0, 1, 8'h22, 2'b01, 0, 32'h0000CAFE, 32'h01020304, 0);
        vecs[13] = mk(0, 1, 0, 8'h20, 2'b10, 0, 32'h0,        32'hCAFE0304, 0);
        vecs[14] = mk(0, 1, 0, 8'h22, 2'b01, 0, 32'h0,        32'hFFFFCAFE, 0);
        vecs[15] = mk(0, 1, 0, 8'h24, 2'b11, 0, 32'h0,        32'hFFFFCAFE, 1);
        vecs[16] = mk(0, 1, 0, 8'h21, 2'b10, 0, 32'h0,        32'hFFFFCAFE, 1);
        vecs[17] = mk(0, 0, 1, 8'h21, 2'b00, 0, 32'hFFFFFF99, 32'hFFFFCAFE, 0);
        vecs[18] = mk(0, 1, 0, 8'h20, 2'b10, 0, 32'h0,        32'hCAFE9904, 0);
        vecs[19] = mk(0, 1, 0, 8'h21, 2'b00, 0, 32'h0,        32'hFFFFFF99, 0);
        vecs[20] = mk(1, 0, 1, 8'h40, 2'b10, 0, 32'h11223344, 32'h00000000, 0);
        vecs[21] = mk(1, 0, 1, 8'h41, 2'b00, 0, 32'h00000077, 32'h00000000, 0);
        vecs[22] = mk(1, 1, 0, 8'h40, 2'b10, 0, 32'h0,        32'h11227744, 0);

        for (int i = 0; i < 23; i++) run_access(vecs[i]);
        run_access(mk(1, 1, 0, 8'h41, 2'b00, 1, 32'h0, 32'h00000077, 0));
        run_access(mk(1, 1, 0, 8'h42, 2'b01, 0, 32'h0, 32'h00001122, 0));
        run_access(mk(1, 1, 0, 8'h43, 2'b01, 0, 32'h0, 32'h00001122, 1));
`ifdef DMEM_STATS_EN
        check("read_count", {16'd0, rcnt[1]}, 32'd3);
        check("write_count", {16'd0, wcnt[1]}, 32'd2);
`endif

        // A request raised while the previous access is in WAIT must be dropped.
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 8'h20; size[0] = 2'b10;
        @(posedge clk);
        @(negedge clk);
        addr[0] = 8'h10;
        cnt = ready[0] ? 1 : 0;
        @(negedge clk);
        idle_inputs(0);
        cnt += ready[0] ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt += ready[0] ? 1 : 0;
        end
        check("wait_ignore_ready_count", 32'(cnt), 32'd1);
        check("wait_ignore_rdata", rdata[0], 32'hCAFE9904);

        // Reset during WAIT aborts a write.
        run_access(mk(0, 0, 1, 8'h30, 2'b10, 0, 32'hA5A5A5A5, 32'hCAFE9904, 0));
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 8'h30; size[0] = 2'b10; wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        idle_inputs(0);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        check("post_reset_rdata", rdata[0], 32'd0);
        check("post_reset_error", {31'd0, err[0]}, 32'd0);
        cnt = ready[0] ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cnt += ready[0] ? 1 : 0;
        end
        check("reset_abort_ready_count", 32'(cnt), 32'd0);
        run_access(mk(0, 1, 0, 8'h30, 2'b10, 0, 32'h0, 32'hA5A5A5A5, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
